// File: rtl/exp6_apresentador_sequencia_if.sv
// ----------------------------------------------------------------------------
// exp6_apresentador_sequencia_if
// Purpose : groups the control/ROM signals of the sequence presenter.
//           Signal names carry the presenter's point of view (i_ = into
//           the presenter, o_ = out of it).
// Signals : i_iniciar   start request
//           i_limite    last ROM address to show
//           i_dado      ROM data (synchronous ROM, 1-cycle latency)
//           o_endereco  ROM address
//           o_leds      element currently shown
//           o_ocupado   presenter busy
//           o_pronto    1-cycle pulse when the sequence has been shown
//           o_db_estado state code for debug
//           i_abortar   abort request (only with EXP6_APRESENTADOR_ABORTA_EN)
// Modports: master = controller/ROM side, slave = presenter.
// ----------------------------------------------------------------------------
interface exp6_apresentador_sequencia_if #(
  parameter int ADDR_W = 4
);
  logic              i_iniciar;
  logic [ADDR_W-1:0] i_limite;
  logic [3:0]        i_dado;
  logic [ADDR_W-1:0] o_endereco;
  logic [3:0]        o_leds;
  logic              o_ocupado;
  logic              o_pronto;
  logic [3:0]        o_db_estado;
`ifdef EXP6_APRESENTADOR_ABORTA_EN
  logic              i_abortar;

  modport master (
    output i_iniciar, i_limite, i_dado, i_abortar,
    input  o_endereco, o_leds, o_ocupado, o_pronto, o_db_estado
  );
  modport slave (
    input  i_iniciar, i_limite, i_dado, i_abortar,
    output o_endereco, o_leds, o_ocupado, o_pronto, o_db_estado
  );
`else
  modport master (
    output i_iniciar, i_limite, i_dado,
    input  o_endereco, o_leds, o_ocupado, o_pronto, o_db_estado
  );
  modport slave (
    input  i_iniciar, i_limite, i_dado,
    output o_endereco, o_leds, o_ocupado, o_pronto, o_db_estado
  );
`endif
endinterface

// File: rtl/exp6_apresentador_sequencia.sv
// ----------------------------------------------------------------------------
// exp6_apresentador_sequencia
// Purpose : plays the stored sequence back on the LEDs. Walks the ROM from
//           address 0 up to a limit latched at start; every element is lit
//           for T_ACESO cycles and followed by a dark gap of T_APAGADO cycles.
// Ports   : i_clock  system clock (rising edge)
//           i_reset  synchronous, active-high; returns to OCIOSO
//           io_bus   exp6_apresentador_sequencia_if.slave (start, limit,
//                    ROM address/data, LEDs, busy, done pulse, state code)
// Option  : EXP6_APRESENTADOR_ABORTA_EN adds i_abortar to the interface and
//           the ABORTADO state (code 5). Without it ABORTADO is unreachable.
// ----------------------------------------------------------------------------
module exp6_apresentador_sequencia #(
  parameter int T_ACESO   = 1000,
  parameter int T_APAGADO = 500,
  parameter int ADDR_W    = 4
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  exp6_apresentador_sequencia_if.slave  io_bus
);

  localparam int T_MAX   = (T_ACESO > T_APAGADO) ? T_ACESO : T_APAGADO;
  localparam int TIMER_W = $clog2(T_MAX) + 1;
  localparam logic [TIMER_W-1:0] ACESO_ULT   = TIMER_W'(T_ACESO - 1);
  localparam logic [TIMER_W-1:0] APAGADO_ULT = TIMER_W'(T_APAGADO - 1);

  typedef enum logic [3:0] {
    S_OCIOSO   = 4'd0,
    S_CARREGA  = 4'd1,
    S_ACESO    = 4'd2,
    S_APAGADO  = 4'd3,
    S_FIM      = 4'd4,
    S_ABORTADO = 4'd5
  } estado_t;

  estado_t           r_estado;
  logic [TIMER_W-1:0] r_timer;
  logic [ADDR_W-1:0] r_endereco;
  logic [ADDR_W-1:0] r_limite;
  logic              r_pronto;
  logic              r_ocupado;

  estado_t           w_estado_prox;
  logic              w_abortar;
  logic              w_aceita;
  logic              w_fim_apagado;

`ifdef EXP6_APRESENTADOR_ABORTA_EN
  assign w_abortar = io_bus.i_abortar;
`else
  assign w_abortar = 1'b0;
`endif

  // Start is only honoured while idle; busy-time requests are dropped.
  assign w_aceita      = (r_estado == S_OCIOSO) && io_bus.i_iniciar;
  // Last gap cycle of an element that was not aborted.
  assign w_fim_apagado = (r_estado == S_APAGADO) && (r_timer == APAGADO_ULT) && !w_abortar;

  // Next-state decode.
  always_comb begin
    w_estado_prox = r_estado;
    case (r_estado)
      S_OCIOSO: begin
        if (io_bus.i_iniciar) w_estado_prox = S_CARREGA;
        else                  w_estado_prox = S_OCIOSO;
      end
      S_CARREGA: begin
        if (w_abortar) w_estado_prox = S_ABORTADO;
        else           w_estado_prox = S_ACESO;
      end
      S_ACESO: begin
        if (w_abortar)                  w_estado_prox = S_ABORTADO;
        else if (r_timer == ACESO_ULT)  w_estado_prox = S_APAGADO;
        else                            w_estado_prox = S_ACESO;
      end
      S_APAGADO: begin
        if (w_abortar)                       w_estado_prox = S_ABORTADO;
        else if (r_timer == APAGADO_ULT) begin
          if (r_endereco == r_limite)        w_estado_prox = S_FIM;
          else                               w_estado_prox = S_CARREGA;
        end else                             w_estado_prox = S_APAGADO;
      end
      S_FIM:      w_estado_prox = S_OCIOSO;
      S_ABORTADO: w_estado_prox = S_OCIOSO;
      default:    w_estado_prox = S_OCIOSO;
    endcase
  end

  // State, timer, address/limit registers and registered status outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_estado   <= S_OCIOSO;
      r_timer    <= {TIMER_W{1'b0}};
      r_endereco <= {ADDR_W{1'b0}};
      r_limite   <= {ADDR_W{1'b0}};
      r_pronto   <= 1'b0;
      r_ocupado  <= 1'b0;
    end else begin
      r_estado <= w_estado_prox;

      // Timer restarts on every state entry and only runs in the timed states.
      if (w_estado_prox != r_estado) begin
        r_timer <= {TIMER_W{1'b0}};
      end else if ((r_estado == S_ACESO) || (r_estado == S_APAGADO)) begin
        r_timer <= r_timer + TIMER_W'(1);
      end else begin
        r_timer <= r_timer;
      end

      // Address only advances when the limit was not yet reached, so it
      // never wraps even with the limit at the top address.
      if (w_aceita) begin
        r_endereco <= {ADDR_W{1'b0}};
        r_limite   <= io_bus.i_limite;
      end else if (w_fim_apagado && (r_endereco != r_limite)) begin
        r_endereco <= r_endereco + ADDR_W'(1);
        r_limite   <= r_limite;
      end else begin
        r_endereco <= r_endereco;
        r_limite   <= r_limite;
      end

      r_pronto  <= (w_estado_prox == S_FIM);
      r_ocupado <= (w_estado_prox != S_OCIOSO);
    end
  end

  assign io_bus.o_endereco  = r_endereco;
  assign io_bus.o_ocupado   = r_ocupado;
  assign io_bus.o_pronto    = r_pronto;
  assign io_bus.o_db_estado = r_estado;
  // LEDs follow the ROM directly while lit; dark in every other state.
  assign io_bus.o_leds      = (r_estado == S_ACESO) ? io_bus.i_dado : 4'd0;

endmodule

// File: tb/tb_exp6_apresentador_sequencia.sv
// ----------------------------------------------------------------------------
// tb_exp6_apresentador_sequencia
// Scoreboard bench: each run pushes the expected element/pronto/idle events
// (hand-computed cycle numbers, T_ACESO=4, T_APAGADO=2, 7 cycles per element)
// and a monitor pops and compares them as the presenter produces them.
// ROM model: dado = (address + 1) mod 16, one-cycle latency.
// ----------------------------------------------------------------------------
module tb_exp6_apresentador_sequencia;

  localparam int K_ELEM   = 0;
  localparam int K_PRONTO = 1;
  localparam int K_IDLE   = 2;
  localparam int SLOT     = 7;

  typedef struct {
    int kind;
    int val;
    int addr;
    int cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   edge_n;
  int   t_start;
  int   n_vec;
  int   n_err;
  bit   mon_en;
  int   cur_led;
  logic [3:0] prev_db;
  logic       prev_oc;
  exp_t sbq[$];

  exp6_apresentador_sequencia_if #(.ADDR_W(4)) bus ();

  exp6_apresentador_sequencia #(
    .T_ACESO  (4),
    .T_APAGADO(2),
    .ADDR_W   (4)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Synchronous ROM model
  always @(posedge clk) bus.i_dado <= 4'(bus.o_endereco + 4'd1);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input int kind, input int val, input int addr, input int cyc);
    exp_t e;
    e.kind = kind; e.val = val; e.addr = addr; e.cyc = cyc;
    sbq.push_back(e);
  endtask

  // Full playback of addresses 0..lim
  task automatic push_full(input int lim);
    for (int i = 0; i <= lim; i++) push(K_ELEM, (i + 1) % 16, i, 2 + SLOT * i);
    push(K_PRONTO, 0, lim, (lim + 1) * SLOT + 1);
    push(K_IDLE, 0, lim, (lim + 1) * SLOT + 2);
  endtask

  task automatic pop_check(input int kind, input int rel);
    exp_t e;
    if (sbq.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, required none", kind, rel);
      return;
    end
    e = sbq.pop_front();
    chk("event_kind", kind, e.kind);
    chk("event_cycle", rel, e.cyc);
    if (kind == K_ELEM) begin
      chk("elem_leds", {28'd0, bus.o_leds}, e.val);
      chk("elem_endereco", {28'd0, bus.o_endereco}, e.addr);
      cur_led = e.val;
    end
    if (kind == K_IDLE) chk("idle_endereco", {28'd0, bus.o_endereco}, e.addr);
  endtask

  // Monitor: detects events on the falling edge and checks them against the queue
  always @(negedge clk) begin
    int rel;
    rel = edge_n - t_start + 1;
    if (mon_en) begin
      if (bus.o_db_estado == 4'd2 && prev_db != 4'd2) pop_check(K_ELEM, rel);
      if (bus.o_pronto === 1'b1) pop_check(K_PRONTO, rel);
      if (bus.o_ocupado === 1'b0 && prev_oc === 1'b1) pop_check(K_IDLE, rel);
      if (bus.o_db_estado == 4'd2) chk("leds_lit", {28'd0, bus.o_leds}, cur_led);
      else                         chk("leds_dark", {28'd0, bus.o_leds}, 32'd0);
    end
    prev_db = bus.o_db_estado;
    prev_oc = bus.o_ocupado;
  end

  // Issue start; afterwards we are in cycle 1 (CARREGA)
  task automatic start(input int lim);
    @(negedge clk);
    bus.i_iniciar = 1'b1;
    bus.i_limite  = 4'(lim);
    t_start = edge_n + 1;
    @(negedge clk);
    bus.i_iniciar = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.o_ocupado !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_vec++; n_err++;
      $display("FAIL wait_idle: got ocupado=%0b after %0d cycles, required 0", bus.o_ocupado, n);
    end
    @(negedge clk);
  endtask

  initial begin
    edge_n = 0; t_start = 0; n_vec = 0; n_err = 0; mon_en = 1'b0; cur_led = 0;
    prev_db = 4'd0; prev_oc = 1'b0;
    rst = 1'b1;
    bus.i_iniciar = 1'b0;
    bus.i_limite  = 4'd0;
`ifdef EXP6_APRESENTADOR_ABORTA_EN
    bus.i_abortar = 1'b0;
`endif
    // 1. reset state
    repeat (2) @(negedge clk);
    chk("rst_leds", {28'd0, bus.o_leds}, 32'd0);
    chk("rst_endereco", {28'd0, bus.o_endereco}, 32'd0);
    chk("rst_ocupado", {31'd0, bus.o_ocupado}, 32'd0);
    chk("rst_pronto", {31'd0, bus.o_pronto}, 32'd0);
    chk("rst_db_estado", {28'd0, bus.o_db_estado}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // 2. three elements
    push_full(2);
    start(2);
    wait_idle();

    // 3. single element
    push_full(0);
    start(0);
    wait_idle();

    // 4. whole ROM, last element dark (dado = 0)
    push_full(15);
    start(15);
    wait_idle();

    // 5a. new start and limit change during playback are ignored
    push_full(3);
    start(3);
    repeat (4) @(negedge clk);           // cycle 5
    bus.i_iniciar = 1'b1;
    bus.i_limite  = 4'd0;
    @(negedge clk);
    bus.i_iniciar = 1'b0;
    wait_idle();

    // 5b. reset at cycle 10: OCIOSO in cycle 11, endereco 0, no pronto
    push(K_ELEM, 1, 0, 2);
    push(K_ELEM, 2, 1, 9);
    push(K_IDLE, 0, 0, 11);
    start(3);
    repeat (9) @(negedge clk);           // cycle 10
    rst = 1'b1;
    @(negedge clk);                      // cycle 11
    rst = 1'b0;
    chk("reset_mid_db_estado", {28'd0, bus.o_db_estado}, 32'd0);
    repeat (3) @(negedge clk);

`ifdef EXP6_APRESENTADOR_ABORTA_EN
    // 6. abort in cycle 3: ABORTADO in cycle 4, OCIOSO in cycle 5
    push(K_ELEM, 1, 0, 2);
    push(K_IDLE, 0, 0, 5);
    start(2);
    repeat (2) @(negedge clk);           // cycle 3
    bus.i_abortar = 1'b1;
    @(negedge clk);                      // cycle 4
    bus.i_abortar = 1'b0;
    chk("abort_db_estado", {28'd0, bus.o_db_estado}, 32'd5);
    @(negedge clk);                      // cycle 5
    chk("abort_idle_db_estado", {28'd0, bus.o_db_estado}, 32'd0);
    repeat (3) @(negedge clk);
`endif

    chk("scoreboard_empty", sbq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
